instr_fetch: RTL and testbench

Instruction fetch unit: the producer of the 32-bit instruction word that the control decoder consumes. Holds the PC, issues in-order word reads to instruction memory, buffers returned words in a small FIFO, presents them to decode with a valid/ready handshake, and applies branch/jump redirects by flushing in-flight and buffered instructions.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_if.sv | 32 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Width of the PC field stored alongside each buffered instruction.
  localparam int unsigned PC_W = 32;

  // addi x0, x0, 0 -- presented to decode whenever nothing is buffered.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus plus the decode-side valid/ready handshake.
// master = fetch unit, slave = memory and decoder.
interface fetch_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
) ();

  logic                     imem_req_o;
  logic [ADDRESS_WIDTH-1:0] imem_addr_o;
  logic                     imem_gnt_i;
  logic                     imem_rvalid_i;
  logic [31:0]              imem_rdata_i;

  logic [31:0]              instr_o;
  logic [ADDRESS_WIDTH-1:0] pc_o;
  logic                     instr_valid_o;
  logic                     instr_ready_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output instr_o, pc_o, instr_valid_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  instr_o, pc_o, instr_valid_o,
    output instr_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries. Flush wins over push and pop; push
// when full and pop when empty are ignored. Head is read straight from
// the storage array, so data_o is valid whenever empty_o is low.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  // Storage write.
  // NOTE: the data array has no reset; only pointers and count need a known
  // state, and an entry is never read before it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy update.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: request PC, credit-based request throttling,
// response PC tracking, redirect flush and discard of stale responses.
// Optional macro FETCH_MISALIGN_CHECK_EN: a redirect to a non-word-aligned
// target halts fetch and raises a sticky misalign_o until the next aligned
// redirect. Without it the low two target bits are ignored.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              FIFO_DEPTH    = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  fetch_if.master                  bus,
  input  logic                     PCsrc_i,
  input  logic [ADDRESS_WIDTH-1:0] target_i
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                     misalign_o
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

  logic [ADDRESS_WIDTH-1:0] pc_q, rsp_pc_q, last_pc_q, target_eff;
  logic [CW-1:0]            outstanding_q, outstanding_d;
  logic [CW-1:0]            discard_q, discard_d;
  logic [CW-1:0]            fifo_count;
  logic [CW:0]              credit_used;
  logic                     start_q, halt;
  logic                     fire, drop, push, pop;
  logic                     fifo_empty, fifo_full;
  fetch_entry_t             push_entry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_q;

  assign target_eff = target_i;
  assign halt       = halt_q;
  assign misalign_o = halt_q;

  // Every redirect re-evaluates alignment: misaligned parks fetch, aligned resumes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      halt_q <= 1'b0;
    else if (PCsrc_i) halt_q <= |target_i[1:0];
  end
`else
  assign target_eff = target_i & ~ADDRESS_WIDTH'(3);
  assign halt       = 1'b0;
`endif

  // Credits cover both in-flight requests and buffered words, so every
  // response is guaranteed a FIFO slot. start_q keeps req low during reset.
  assign credit_used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign bus.imem_req_o  = start_q && !halt && (credit_used < DEPTH_LIM);
  assign bus.imem_addr_o = pc_q;

  assign fire = bus.imem_req_o && bus.imem_gnt_i;
  // A response arriving with a redirect belongs to the old stream.
  assign drop = bus.imem_rvalid_i && (PCsrc_i || (discard_q != '0));
  assign push = bus.imem_rvalid_i && !drop;
  assign pop  = bus.instr_valid_o && bus.instr_ready_i && !PCsrc_i;

  assign push_entry = '{instr: bus.imem_rdata_i, pc: PC_W'(rsp_pc_q)};

  // Outstanding and discard bookkeeping for this cycle's grant/response events.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    outstanding_d = outstanding_q + CW'(fire) - CW'(bus.imem_rvalid_i);
    discard_d     = discard_q;
    if (PCsrc_i) begin
      // Everything still owed after this cycle is stale, including a request
      // granted right now; this also folds in any earlier pending discards.
      discard_d = outstanding_d;
    end else if (bus.imem_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  // PC, response PC and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q       <= 1'b0;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      start_q       <= 1'b1;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (PCsrc_i) begin
        pc_q     <= target_eff;
        rsp_pc_q <= target_eff;
      end else begin
        if (fire) pc_q     <= pc_q + ADDRESS_WIDTH'(4);
        if (push) rsp_pc_q <= rsp_pc_q + ADDRESS_WIDTH'(4);
      end
    end
  end

  // Remember the last presented PC so pc_o holds steady while the buffer is empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          last_pc_q <= '0;
    else if (!fifo_empty) last_pc_q <= ADDRESS_WIDTH'(head.pc);
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (PCsrc_i),
    .data_i  (push_entry),
    .data_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.instr_valid_o = !fifo_empty;
  assign bus.instr_o       = fifo_empty ? NOP_INSTR : head.instr;
  assign bus.pc_o          = fifo_empty ? last_pc_q : ADDRESS_WIDTH'(head.pc);

  // The credit rule must never let a response meet a full buffer.
  ap_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !fifo_full);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a behavioural instruction memory
// (configurable latency, switchable grant) and an in-order delivery scoreboard.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic          clk    = 1'b0;
  logic          rst_ni = 1'b0;
  logic          pcsrc  = 1'b0;
  logic [AW-1:0] target = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          misalign;
`endif

  fetch_if #(.ADDRESS_WIDTH(AW)) bus ();

  instr_fetch #(
    .ADDRESS_WIDTH (AW),
    .FIFO_DEPTH    (DEPTH),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .bus      (bus),
    .PCsrc_i  (pcsrc),
    .target_i (target)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o (misalign)
`endif
  );

  always #5 clk = ~clk;

  mreq_t       mq[$];
  int          cyc, checks, errors, ngrant, ndeliv, first_req, first_valid, lat, n;
  bit          gnt_en, ready, cond;
  logic [31:0] exp_pc, a0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at a falling edge: drive memory and
  // decode inputs, log grants, score deliveries, then advance.
  task automatic tick();
    bus.imem_gnt_i    = gnt_en;
    bus.instr_ready_i = ready;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
    end
    if (bus.imem_req_o && first_req < 0) first_req = cyc;
    if (bus.imem_req_o && gnt_en) begin
      mq.push_back('{addr: bus.imem_addr_o, due: cyc + lat});
      ngrant++;
    end
    if (bus.instr_valid_o && first_valid < 0) first_valid = cyc;
    if (bus.instr_valid_o && ready && !pcsrc) begin
      check("deliver_pc", bus.pc_o, exp_pc);
      check("deliver_instr", bus.instr_o, mem_word(exp_pc));
      exp_pc += 32'd4;
      ndeliv++;
    end
    if (pcsrc) exp_pc = target & ~32'h3;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_valid(input int budget, output int waited);
    waited = 0;
    while (!bus.instr_valid_o && waited < budget) begin
      tick();
      waited++;
    end
    check("wait_valid", {31'd0, bus.instr_valid_o}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] t);
    pcsrc  = 1'b1;
    target = t;
    tick();
    pcsrc  = 1'b0;
  endtask

  initial begin
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
    bus.instr_ready_i = 1'b0;
    gnt_en = 1'b1; ready = 1'b1; lat = 1; exp_pc = 32'h0;
    first_req = -1; first_valid = -1; checks = 0; errors = 0;
    ngrant = 0; ndeliv = 0; cyc = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req",   {31'd0, bus.imem_req_o},    32'd0);
    check("rst_addr",  bus.imem_addr_o,            32'h0);
    check("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    check("rst_instr", bus.instr_o,                32'h0000_0013);
    check("rst_pc",    bus.pc_o,                   32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misalign", {31'd0, misalign}, 32'd0);
`endif

    // Streaming from reset: 1-cycle memory, always granted, always ready.
    rst_ni = 1'b1;
    cyc    = 0;
    repeat (20) tick();
    check("first_req_cycle",   first_req,   32'd1);
    check("first_valid_cycle", first_valid, 32'd3);

    // Backpressure: buffer fills to FIFO_DEPTH, requests stop, then resume.
    ready = 1'b0;
    repeat (8) tick();
    check("bp_req_low",     {31'd0, bus.imem_req_o},    32'd0);
    check("bp_valid",       {31'd0, bus.instr_valid_o}, 32'd1);
    check("bp_head_pc",     bus.pc_o,                   exp_pc);
    check("bp_held_words",  ngrant - ndeliv,            DEPTH);
    ready = 1'b1;
    tick();
    check("bp_resume_req",  {31'd0, bus.imem_req_o},    32'd1);
    repeat (10) tick();

    // Redirect with two responses still owed by a slow memory.
    lat = 3;
    n = 0;
    while (mq.size() != 2 && n < 30) begin tick(); n++; end
    check("rd_two_outstanding", mq.size(), 32'd2);
    redirect(32'h100);
    check("rd_valid_r1", {31'd0, bus.instr_valid_o}, 32'd0);
    check("rd_addr_r1",  bus.imem_addr_o,            32'h100);
    wait_valid(30, n);
    check("rd_first_pc", bus.pc_o, 32'h100);
    check("rd_latency",  {31'd0, n >= 2}, 32'd1);
    lat = 1;
    repeat (8) tick();

    // Redirect coinciding with a response and a decode pop.
    n = 0;
    cond = 1'b0;
    while (!cond && n < 30) begin
      cond = bus.instr_valid_o && mq.size() > 0 && mq[0].due <= cyc;
      if (!cond) begin tick(); n++; end
    end
    check("sc_setup", {31'd0, cond}, 32'd1);
    redirect(32'h240);
    check("sc_valid_r1", {31'd0, bus.instr_valid_o}, 32'd0);
    check("sc_addr_r1",  bus.imem_addr_o,            32'h240);
    wait_valid(30, n);
    check("sc_first_pc", bus.pc_o, 32'h240);
    repeat (6) tick();

    // Grant withheld for 5 cycles: request and address hold steady.
    gnt_en = 1'b0;
    repeat (3) tick();
    a0 = bus.imem_addr_o;
    check("gl_addr_next", a0, exp_pc);
    for (int i = 0; i < 5; i++) begin
      check("gl_req",  {31'd0, bus.imem_req_o}, 32'd1);
      check("gl_addr", bus.imem_addr_o, a0);
      tick();
    end
    gnt_en = 1'b1;
    check("gl_req_at_gnt", {31'd0, bus.imem_req_o}, 32'd1);
    tick();
    check("gl_addr_after", bus.imem_addr_o, a0 + 32'd4);
    repeat (6) tick();

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetch until an aligned one arrives.
    redirect(32'h102);
    check("mis_flag",  {31'd0, misalign},          32'd1);
    check("mis_req",   {31'd0, bus.imem_req_o},    32'd0);
    check("mis_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    repeat (4) tick();
    check("mis_req_hold",  {31'd0, bus.imem_req_o}, 32'd0);
    check("mis_flag_hold", {31'd0, misalign},       32'd1);
    redirect(32'h200);
    check("mis_clear",     {31'd0, misalign},       32'd0);
    check("mis_addr",      bus.imem_addr_o,         32'h200);
    check("mis_req_again", {31'd0, bus.imem_req_o}, 32'd1);
    wait_valid(30, n);
    check("mis_first_pc", bus.pc_o, 32'h200);
    repeat (4) tick();
`else
    // Low target bits are ignored.
    redirect(32'h10A);
    check("al_addr", bus.imem_addr_o, 32'h108);
    wait_valid(30, n);
    check("al_first_pc", bus.pc_o, 32'h108);
    repeat (4) tick();
`endif

    // Asynchronous reset in the middle of streaming.
    rst_ni = 1'b0;
    #1;
    check("mrst_req",   {31'd0, bus.imem_req_o},    32'd0);
    check("mrst_addr",  bus.imem_addr_o,            32'h0);
    check("mrst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    check("mrst_instr", bus.instr_o,                32'h0000_0013);
    check("mrst_pc",    bus.pc_o,                   32'h0);
    mq.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
